// File: rtl/add_one_pkg.sv
// rtl/add_one_pkg.sv - shared types, widths and the wrapping increment for the add-one scheduler
package add_one_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;

  localparam int ADD_ONE_DATA_W = 32;
  localparam int ADD_ONE_MAX_W  = 64;

  // Increment within a w-bit field; the carry out of bit w-1 is dropped.
  function automatic logic [ADD_ONE_MAX_W-1:0] inc_wrap(input logic [ADD_ONE_MAX_W-1:0] v,
                                                        input int unsigned w);
    logic [ADD_ONE_MAX_W-1:0] mask;
    mask = (w >= ADD_ONE_MAX_W) ? '1 : ((ADD_ONE_MAX_W'(1) << w) - ADD_ONE_MAX_W'(1));
    return (v + ADD_ONE_MAX_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_any
);

  int j;

  // Scan from farthest to nearest so the candidate closest to ptr is assigned last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = W'(j);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_one_rr_sched.sv
// rtl/add_one_rr_sched.sv - round-robin share of one add-one unit among N_REQ cores
// Optional response-hold timeout: ADD_ONE_SCHED_TIMEOUT_EN
module add_one_rr_sched
  import add_one_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = ADD_ONE_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy,
  output logic                    timeout_flag
);

  localparam int PTR_W = $clog2(N_REQ);

  sched_state_t      state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  arb_idx;
  logic [PTR_W-1:0]  ptr_after_gnt;
  logic [N_REQ-1:0]  arb_grant;
  logic              arb_any;
  logic              rsp_hs;
  logic [DATA_W-1:0] operand;

  rr_arbiter #(.N(N_REQ), .W(PTR_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // Gated by reset so no core sees an acceptance while the block is held in reset.
  assign req_ready     = (S_AXI_ARESETN && state == IDLE) ? arb_grant : '0;
  assign busy          = (state != IDLE);
  assign rsp_hs        = rsp_ready[gnt_idx];
  assign ptr_after_gnt = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

`ifdef ADD_ONE_SCHED_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_flag_q;
  assign timeout_flag = tmo_flag_q;
`else
  assign timeout_flag = (TIMEOUT < 0);
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      operand   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
`ifdef ADD_ONE_SCHED_TIMEOUT_EN
      tmo_cnt    <= '0;
      tmo_flag_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_idx <= arb_idx;
            operand <= req_data[int'(arb_idx)*DATA_W +: DATA_W];
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= DATA_W'(inc_wrap(ADD_ONE_MAX_W'(operand), DATA_W));
          rsp_valid <= N_REQ'(1) << gnt_idx;
          state     <= RESP;
`ifdef ADD_ONE_SCHED_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid <= '0;
            ptr       <= ptr_after_gnt;
            state     <= IDLE;
          end
`ifdef ADD_ONE_SCHED_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            rsp_valid  <= '0;
            ptr        <= ptr_after_gnt;
            state      <= IDLE;
            tmo_flag_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_one_rr_sched.sv
// tb/tb_add_one_rr_sched.sv - directed self-checking bench for add_one_rr_sched
module tb_add_one_rr_sched;

  logic         S_AXI_ACLK = 1'b0;
  logic         S_AXI_ARESETN;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_data;
  logic         busy;
  logic         timeout_flag;

  int checks = 0;
  int errors = 0;

  add_one_rr_sched #(.N_REQ(4), .DATA_W(32), .TIMEOUT(16)) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .timeout_flag  (timeout_flag)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  task automatic tick;
    @(posedge S_AXI_ACLK);
    #2;
  endtask

  task automatic test_reset;
    S_AXI_ARESETN = 1'b0;
    req_valid = 4'hF;
    req_data = {32'h4, 32'h3, 32'h2, 32'h1};
    rsp_ready = 4'h0;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
      checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_timeout_flag got %b exp 0", timeout_flag); end
    S_AXI_ARESETN = 1'b1;
    req_valid = 4'h0;
    tick;
  endtask

  task automatic test_single;
    req_valid = 4'b0100;
    req_data[64 +: 32] = 32'h0000_0041;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready got %b exp 0100", req_ready); end
    tick;
    req_valid = 4'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_exec got %b exp 1", busy); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL single_rsp_early got %b exp 0000", rsp_valid); end
    tick;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got %b exp 0100", rsp_valid); end
    checks++; if (rsp_data !== 32'h0000_0042) begin errors++; $display("FAIL single_rsp_data got %h exp 00000042", rsp_data); end
    rsp_ready = 4'b0100;
    tick;
    rsp_ready = 4'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b exp 0", busy); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL single_rsp_clear got %b exp 0000", rsp_valid); end
  endtask

  task automatic test_wrap;
    req_valid = 4'b0001;
    req_data[0 +: 32] = 32'hFFFF_FFFF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_req_ready got %b exp 0001", req_ready); end
    tick;
    req_valid = 4'b0;
    tick;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL wrap_rsp_valid got %b exp 0001", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL wrap_rsp_data got %h exp 00000000", rsp_data); end
    rsp_ready = 4'b0001;
    tick;
    rsp_ready = 4'b0;
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL wrap_timeout_flag got %b exp 0", timeout_flag); end
  endtask

  task automatic test_fairness;
    logic [3:0] exp_oh;
    int exp_core;
    S_AXI_ARESETN = 1'b0;
    tick;
    S_AXI_ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'(i*256 + 16);
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_core = k % 4;
      exp_oh = 4'(1 << exp_core);
      checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", k, req_ready, exp_oh); end
      tick;
      tick;
      checks++; if (rsp_valid !== exp_oh) begin errors++; $display("FAIL fair_rsp_valid%0d got %b exp %b", k, rsp_valid, exp_oh); end
      checks++; if (rsp_data !== 32'(exp_core*256 + 17)) begin errors++; $display("FAIL fair_rsp_data%0d got %h exp %h", k, rsp_data, 32'(exp_core*256 + 17)); end
      tick;
    end
    req_valid = 4'b0;
    rsp_ready = 4'b0;
  endtask

  task automatic test_stall;
    req_valid = 4'b0010;
    req_data[32 +: 32] = 32'h1234_5677;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_req_ready1 got %b exp 0010", req_ready); end
    tick;
    req_valid = 4'b1000;
    req_data[96 +: 32] = 32'hAAAA_0000;
    rsp_ready = 4'b1000;
    tick;
    for (int c = 0; c < 10; c++) begin
      checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL stall_rsp_valid c%0d got %b exp 0010", c, rsp_valid); end
      checks++; if (rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL stall_rsp_data c%0d got %h exp 12345678", c, rsp_data); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL stall_req_ready3 c%0d got %b exp 0000", c, req_ready); end
      tick;
    end
`ifndef ADD_ONE_SCHED_TIMEOUT_EN
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL stall_timeout_flag got %b exp 0", timeout_flag); end
`endif
    rsp_ready = 4'b0010;
    tick;
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL stall_rsp_clear got %b exp 0000", rsp_valid); end
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stall_core3_grant got %b exp 1000", req_ready); end
    rsp_ready = 4'hF;
    tick;
    req_valid = 4'b0;
    tick;
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL stall_core3_rsp got %b exp 1000", rsp_valid); end
    checks++; if (rsp_data !== 32'hAAAA_0001) begin errors++; $display("FAIL stall_core3_data got %h exp aaaa0001", rsp_data); end
    tick;
    rsp_ready = 4'b0;
  endtask

  task automatic test_reset_mid_resp;
    req_valid = 4'b0010;
    rsp_ready = 4'hF;
    tick;
    req_valid = 4'b0;
    tick;
    tick;
    rsp_ready = 4'b0;
    req_valid = 4'b1000;
    req_data[96 +: 32] = 32'h0000_0007;
    tick;
    req_valid = 4'b0;
    tick;
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL midrst_rsp_before got %b exp 1000", rsp_valid); end
    S_AXI_ARESETN = 1'b0;
    req_valid = 4'hF;
    req_data[0 +: 32] = 32'h0000_0055;
    tick;
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL midrst_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL midrst_rsp_data got %h exp 0", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL midrst_req_ready got %b exp 0000", req_ready); end
    S_AXI_ARESETN = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got %b exp 0001", req_ready); end
    tick;
    req_valid = 4'b0;
    tick;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL midrst_rsp_core0 got %b exp 0001", rsp_valid); end
    checks++; if (rsp_data !== 32'h0000_0056) begin errors++; $display("FAIL midrst_data_core0 got %h exp 00000056", rsp_data); end
    rsp_ready = 4'hF;
    tick;
    rsp_ready = 4'b0;
  endtask

`ifdef ADD_ONE_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int held;
    S_AXI_ARESETN = 1'b0;
    tick;
    S_AXI_ARESETN = 1'b1;
    req_valid = 4'b0011;
    req_data[0 +: 32] = 32'h5;
    req_data[32 +: 32] = 32'h9;
    rsp_ready = 4'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL tmo_grant0 got %b exp 0001", req_ready); end
    tick;
    req_valid = 4'b0010;
    tick;
    held = 0;
    for (int c = 0; c < 40 && rsp_valid === 4'b0001; c++) begin
      held++;
      tick;
    end
    checks++; if (held != 16) begin errors++; $display("FAIL tmo_hold_cycles got %0d exp 16", held); end
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b exp 1", timeout_flag); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL tmo_next_grant got %b exp 0010", req_ready); end
    req_valid = 4'b0;
    rsp_ready = 4'hF;
    tick;
    tick;
    tick;
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_flag_sticky got %b exp 1", timeout_flag); end
    rsp_ready = 4'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_fairness;
    test_stall;
    test_reset_mid_resp;
`ifdef ADD_ONE_SCHED_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
